rr_multiplexor: RTL and testbench
=================================

// Module: rr_multiplexor
// PURPOSE
//   Parametrised N:1 multiplexor with round-robin arbitration, per-channel valid/ready
//   handshake and a registered output stage. Shares one datapath resource (bus or
//   memory port) among CHANNELS requesters in the VeriRISC datapath.
//   Generalises the 2:1 combinational multiplexor in width, channel count and flow control.
// PARAMETERS
//   WIDTH     8   data width per channel, >=1
//   CHANNELS  4   number of input channels, >=1
//   SEL_W     (localparam) max(1,$clog2(CHANNELS)); width of out_sel
// PORTS
//   clk       in   1                 rising-edge clock
//   rst       in   1                 synchronous reset, active-high
//   in_valid  in   CHANNELS          per-channel request; bit i = channel i
//   in_data   in   CHANNELS*WIDTH    packed data; channel i at [i*WIDTH +: WIDTH]
//   in_ready  out  CHANNELS          one-hot or zero; beat i accepted when in_valid[i]&in_ready[i]
//   out_valid out  1                 output register holds a beat
//   out_data  out  WIDTH             registered data
//   out_sel   out  SEL_W             channel index that supplied out_data
//   out_ready in   1                 downstream accepts beat when out_valid&out_ready
//   in_last   in   CHANNELS          only with MUX_LOCK_EN; marks final beat of a packet
// BEHAVIOUR
//   - Reset (sync, rst=1 at clk edge): out_valid=0, out_data=0, out_sel=0, ptr=CHANNELS-1,
//     lock cleared. While rst=1, in_ready=0 (combinationally gated). Mid-op reset discards held beat.
//   - Output register: one entry, two states EMPTY (out_valid=0) / FULL (out_valid=1).
//     load = !out_valid | out_ready  (accept when empty or draining same cycle; no bubble).
//   - Arbitration (combinational): grant g = first channel with in_valid set, searching
//     ptr+1, ptr+2, ... wrapping mod CHANNELS. Channel 0 wins first after reset.
//   - in_ready[g] = load & |in_valid & !rst; all other bits 0. No valid -> in_ready=0.
//   - Transfer (in_valid[g]&in_ready[g]): next edge out_valid=1, out_data=in_data[g],
//     out_sel=g, ptr=g. Latency input->output: 1 cycle.
//   - Drain without transfer (out_valid&out_ready, no new beat): out_valid=0; out_data/out_sel hold.
//   - Stall (out_valid&!out_ready): out_data/out_sel/out_valid hold, in_ready=0, ptr holds.
//   - Simultaneous drain + transfer: FULL->FULL with new beat; throughput 1 beat/cycle.
//   - Pointer only advances on transfer; idle cycles do not rotate priority.
//   - in_valid change while not granted is legal; granted channel is not sampled until transfer.
//   - CHANNELS=1: grant always channel 0, out_sel=0; behaves as registered pipeline stage.
// CONFIGURATION
//   MUX_LOCK_EN defined: in_last port present. A transfer from g with in_last[g]=0 sets
//     lock; while locked, grant forced to g (other channels in_ready=0 even if g idle)
//     until a transfer from g with in_last[g]=1 clears lock; ptr updates normally.
//   MUX_LOCK_EN undefined: no in_last port, no lock; every beat re-arbitrates.
// TESTING
//   1 rst=1 two cycles, all in_valid=1 -> out_valid=0, out_data=0, out_sel=0, in_ready=0.
//   2 in_valid=4'b0100, ch2 data=8'h15, out_ready=1 -> in_ready=4'b0100; next cycle
//     out_valid=1, out_data=8'h15, out_sel=2.
//   3 in_valid=4'b1111 held, data ch i=8'h0A+i, out_ready=1 -> out_sel 0,1,2,3,0 on
//     consecutive cycles, out_data 0A,0B,0C,0D,0A, out_valid continuously 1.
//   4 out_valid=1, out_ready=0 for 3 cycles -> out_data stable, in_ready=0; out_ready=1 ->
//     next beat loaded on that edge, out_valid stays 1 (no bubble).
//   5 rst=1 for one cycle while out_valid=1, in_valid=4'b0010 -> out_valid=0 next cycle;
//     after release ch1 granted next (ptr reset, ch0 idle).
//   6 MUX_LOCK_EN: ch1 sends 3 beats, in_last=1 on third; ch0 valid throughout ->
//     out_sel 1,1,1,0; in_ready[0]=0 during lock.

Source files
------------

// File: rtl/rr_multiplexor.sv
// N:1 round-robin multiplexor with per-channel valid/ready and a one-entry registered output.
// Optional packet locking is enabled by defining MUX_LOCK_EN (adds the in_last port).
module rr_multiplexor #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready
`ifdef MUX_LOCK_EN
   ,
   input  logic [CHANNELS-1:0]       in_last
`endif
);

   typedef enum logic {EMPTY, FULL} state_t;

   state_t              state_reg, state_next;
   logic [WIDTH-1:0]    out_data_reg;
   logic [SEL_W-1:0]    out_sel_reg;
   logic [SEL_W-1:0]    ptr_reg;
   logic [SEL_W-1:0]    grant_idx;
   logic                grant_found;
   logic                load;
   logic                transfer;
   logic [SEL_W:0]      shamt;
   logic [2*CHANNELS-1:0] valid_dbl;
   logic [CHANNELS-1:0] valid_rot;
   logic [WIDTH-1:0]    chan_data [CHANNELS];
   int                  offs;
`ifdef MUX_LOCK_EN
   logic                lock_reg;
`endif

   assign load = (state_reg == EMPTY) | out_ready;

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
         assign in_ready[gi]  = load & grant_found & !rst & (grant_idx == SEL_W'(gi));
      end
   endgenerate

   // Rotate requests so that bit 0 is channel ptr+1; lowest set bit wins.
   assign shamt     = (SEL_W+1)'(ptr_reg) + (SEL_W+1)'(1);
   assign valid_dbl = {in_valid, in_valid};
   assign valid_rot = CHANNELS'(valid_dbl >> shamt);

   always_comb begin
      grant_found = 1'b0;
      offs        = 0;
      for (int j = CHANNELS-1; j >= 0; j--) begin
         if (valid_rot[j]) begin
            grant_found = 1'b1;
            offs        = j;
         end
      end
      grant_idx = SEL_W'((int'(ptr_reg) + 1 + offs) % CHANNELS);
`ifdef MUX_LOCK_EN
      // ptr always names the last transferring channel, i.e. the lock owner.
      if (lock_reg) begin
         grant_idx   = ptr_reg;
         grant_found = in_valid[ptr_reg];
      end
`endif
   end

   assign transfer = |(in_valid & in_ready);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY:   if (transfer) state_next = FULL;
         FULL:    if (out_ready && !transfer) state_next = EMPTY;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= EMPTY;
         out_data_reg <= '0;
         out_sel_reg  <= '0;
         ptr_reg      <= SEL_W'(CHANNELS-1);
`ifdef MUX_LOCK_EN
         lock_reg     <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         if (transfer) begin
            out_data_reg <= chan_data[grant_idx];
            out_sel_reg  <= grant_idx;
            ptr_reg      <= grant_idx;
`ifdef MUX_LOCK_EN
            lock_reg     <= !in_last[grant_idx];
`endif
         end
      end
   end

   assign out_valid = (state_reg == FULL);
   assign out_data  = out_data_reg;
   assign out_sel   = out_sel_reg;

endmodule

// File: tb/tb_rr_multiplexor.sv
// Self-checking bench for rr_multiplexor (WIDTH=8, CHANNELS=4): directed vector table,
// randomized traffic against a round-robin reference model, and a lock sequence when MUX_LOCK_EN is set.
module tb_rr_multiplexor;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  in_valid;
   logic [31:0] in_data;
   logic [3:0]  in_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_sel;
   logic        out_ready;
   logic [3:0]  in_last;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rr_multiplexor #(.WIDTH(8), .CHANNELS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
`ifdef MUX_LOCK_EN
      ,
      .in_last   (in_last)
`endif
   );

   typedef struct {
      logic        r;
      logic [3:0]  iv;
      logic        ordy;
      logic [31:0] d;
      logic [3:0]  e_rdy;
      logic        e_ov;
      logic [7:0]  e_od;
      logic [1:0]  e_os;
   } vec_t;

   localparam logic [31:0] D0 = 32'h0D0C0B0A;
   localparam logic [31:0] D2 = 32'h0D150B0A;

   vec_t vecs [21];

   task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s %s: got %0h want %0h", tag, what, act, exp);
      end
   endtask

   // One clock cycle: drive after negedge, check in_ready before posedge, outputs after it.
   task automatic step(input logic r, input logic [3:0] iv, input logic o, input logic [31:0] d,
                       input logic [3:0] l, input logic [3:0] e_rdy, input logic e_ov,
                       input logic [7:0] e_od, input logic [1:0] e_os, input string tag);
      @(negedge clk);
      rst = r; in_valid = iv; out_ready = o; in_data = d; in_last = l;
      #1;
      chk(tag, "in_ready", 32'(in_ready), 32'(e_rdy));
      @(posedge clk);
      #1;
      chk(tag, "out_valid", 32'(out_valid), 32'(e_ov));
      chk(tag, "out_data", 32'(out_data), 32'(e_od));
      chk(tag, "out_sel", 32'(out_sel), 32'(e_os));
      $display("step %s rst=%b iv=%b ordy=%b rdy=%b ov=%b od=%h os=%0d",
               tag, r, iv, o, in_ready, out_valid, out_data, out_sel);
   endtask

   logic        m_valid;
   logic [7:0]  m_data;
   logic [1:0]  m_sel;
   int          m_ptr;

   initial begin
      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0; in_last = 4'hF;

      //            rst  iv       ordy  data  e_rdy    ov    od     os
      vecs[0]  = '{1'b1, 4'b1111, 1'b1, D0, 4'b0000, 1'b0, 8'h00, 2'd0};
      vecs[1]  = '{1'b1, 4'b1111, 1'b1, D0, 4'b0000, 1'b0, 8'h00, 2'd0};
      vecs[2]  = '{1'b0, 4'b0100, 1'b1, D2, 4'b0100, 1'b1, 8'h15, 2'd2};
      vecs[3]  = '{1'b1, 4'b0000, 1'b1, D0, 4'b0000, 1'b0, 8'h00, 2'd0};
      vecs[4]  = '{1'b0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 8'h0A, 2'd0};
      vecs[5]  = '{1'b0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 8'h0B, 2'd1};
      vecs[6]  = '{1'b0, 4'b1111, 1'b1, D0, 4'b0100, 1'b1, 8'h0C, 2'd2};
      vecs[7]  = '{1'b0, 4'b1111, 1'b1, D0, 4'b1000, 1'b1, 8'h0D, 2'd3};
      vecs[8]  = '{1'b0, 4'b1111, 1'b1, D0, 4'b0001, 1'b1, 8'h0A, 2'd0};
      vecs[9]  = '{1'b0, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 8'h0A, 2'd0};
      vecs[10] = '{1'b0, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 8'h0A, 2'd0};
      vecs[11] = '{1'b0, 4'b1111, 1'b0, D0, 4'b0000, 1'b1, 8'h0A, 2'd0};
      vecs[12] = '{1'b0, 4'b1111, 1'b1, D0, 4'b0010, 1'b1, 8'h0B, 2'd1};
      vecs[13] = '{1'b1, 4'b0010, 1'b0, D0, 4'b0000, 1'b0, 8'h00, 2'd0};
      vecs[14] = '{1'b0, 4'b0010, 1'b0, D0, 4'b0010, 1'b1, 8'h0B, 2'd1};
      vecs[15] = '{1'b0, 4'b0000, 1'b1, D0, 4'b0000, 1'b0, 8'h0B, 2'd1};
      vecs[16] = '{1'b0, 4'b0000, 1'b1, D0, 4'b0000, 1'b0, 8'h0B, 2'd1};
      vecs[17] = '{1'b0, 4'b1001, 1'b1, D0, 4'b1000, 1'b1, 8'h0D, 2'd3};
      vecs[18] = '{1'b0, 4'b1001, 1'b1, D0, 4'b0001, 1'b1, 8'h0A, 2'd0};
      vecs[19] = '{1'b0, 4'b0000, 1'b1, D0, 4'b0000, 1'b0, 8'h0A, 2'd0};
      vecs[20] = '{1'b0, 4'b0001, 1'b1, D0, 4'b0001, 1'b1, 8'h0A, 2'd0};

      for (int i = 0; i < 21; i++)
         step(vecs[i].r, vecs[i].iv, vecs[i].ordy, vecs[i].d, 4'hF,
              vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_os, $sformatf("vec%0d", i));

`ifdef MUX_LOCK_EN
      step(1'b1, 4'b0000, 1'b1, D0, 4'hF,    4'b0000, 1'b0, 8'h00, 2'd0, "lock_rst");
      step(1'b0, 4'b0001, 1'b1, D0, 4'hF,    4'b0001, 1'b1, 8'h0A, 2'd0, "lock_ch0");
      step(1'b0, 4'b0011, 1'b1, D0, 4'b1101, 4'b0010, 1'b1, 8'h0B, 2'd1, "lock_b1");
      step(1'b0, 4'b0011, 1'b1, D0, 4'b1101, 4'b0010, 1'b1, 8'h0B, 2'd1, "lock_b2");
      step(1'b0, 4'b0011, 1'b1, D0, 4'hF,    4'b0010, 1'b1, 8'h0B, 2'd1, "lock_b3");
      step(1'b0, 4'b0011, 1'b1, D0, 4'hF,    4'b0001, 1'b1, 8'h0A, 2'd0, "lock_rel");
`endif

      // Randomized traffic: model keeps the output beat and the last-granted channel.
      m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 3;
      for (int c = 0; c < 2000; c++) begin
         logic        r, o;
         logic [3:0]  iv, e_rdy;
         logic [31:0] d;
         int          g;
         r  = (c == 0) || ($urandom_range(0, 31) == 0);
         iv = 4'($urandom);
         o  = ($urandom_range(0, 3) != 0);
         d  = $urandom;
         e_rdy = '0;
         g = -1;
         if (!r && (!m_valid || o)) begin
            for (int k = 1; k <= 4; k++) begin
               int idx;
               idx = (m_ptr + k) % 4;
               if (iv[idx] && g < 0) g = idx;
            end
            if (g >= 0) e_rdy[g] = 1'b1;
         end
         if (r) begin
            m_valid = 1'b0; m_data = '0; m_sel = '0; m_ptr = 3;
         end else if (g >= 0) begin
            m_valid = 1'b1; m_data = d[g*8 +: 8]; m_sel = 2'(g); m_ptr = g;
         end else if (o) begin
            m_valid = 1'b0;
         end
         step(r, iv, o, d, 4'hF, e_rdy, m_valid, m_data, m_sel, $sformatf("rand%0d", c));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
